// File: rtl/ysyx_23060240_trap_ctrl.sv
// Trap / CSR sequencer: serialises ECALL, MRET and CSRRW/S/C into
// single-access CSR file cycles and emits a completion pulse plus an
// optional pc redirect.
module ysyx_23060240_trap_ctrl #(
    parameter logic [31:0] CAUSE_ECALL = 32'h0000000b,
    parameter logic [1:0]  MPP_M       = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_pc,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [11:0] csr_addr,
    output logic [31:0] w_csr_data,
    output logic        w_csr_en,
    output logic        r_csr_en,
    input  logic [31:0] r_csr_data,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [2:0] OP_ECALL = 3'd0;
    localparam logic [2:0] OP_MRET  = 3'd1;
    localparam logic [2:0] OP_CSRRW = 3'd2;
    localparam logic [2:0] OP_CSRRS = 3'd3;
    localparam logic [2:0] OP_CSRRC = 3'd4;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    typedef enum logic [3:0] {
        IDLE, CSR_RD, CSR_WR, E_EPC, E_CAUSE, E_SRD, E_SWR, E_VEC,
        M_SRD, M_SWR, M_EPC, RESP
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] pc_q, pc_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;      // old CSR value / mstatus snapshot
    logic [31:0] target_q, target_d;

    logic is_csr_op;
    logic is_trap_op;
    assign is_csr_op  = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
    assign is_trap_op = (op_q == OP_ECALL) || (op_q == OP_MRET);

    // State and latched request registers; reset aborts any sequence
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            pc_q     <= 32'd0;
            addr_q   <= 12'd0;
            wdata_q  <= 32'd0;
            old_q    <= 32'd0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            old_q    <= old_d;
            target_q <= target_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    unique case (req_op)
                        OP_ECALL: state_d = E_EPC;
                        OP_MRET:  state_d = M_SRD;
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_d = CSR_RD;
                        default:  state_d = RESP;
                    endcase
                end
            end
            // Set/clear with a zero mask has no side effect, so skip the write
            CSR_RD:  state_d = ((op_q != OP_CSRRW) && (wdata_q == 32'd0)) ? RESP : CSR_WR;
            CSR_WR:  state_d = RESP;
            E_EPC:   state_d = E_CAUSE;
            E_CAUSE: state_d = E_SRD;
            E_SRD:   state_d = E_SWR;
            E_SWR:   state_d = E_VEC;
            E_VEC:   state_d = RESP;
            M_SRD:   state_d = M_SWR;
            M_SWR:   state_d = M_EPC;
            M_EPC:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture and read-data snapshots
    always_comb begin
        op_d     = op_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        target_d = target_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    pc_d     = req_pc;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    old_d    = 32'd0;
                    target_d = 32'd0;
                end
            end
            CSR_RD, E_SRD, M_SRD: old_d = r_csr_data;
            E_VEC:   target_d = {r_csr_data[31:2], 2'b00};
            M_EPC:   target_d = r_csr_data;
            default: ;
        endcase
    end

    // Per-state CSR strobes and response outputs; data buses zero when idle
    always_comb begin
        req_ready      = (state_q == IDLE);
        busy           = (state_q != IDLE);
        csr_addr       = 12'd0;
        w_csr_data     = 32'd0;
        w_csr_en       = 1'b0;
        r_csr_en       = 1'b0;
        done           = 1'b0;
        rd_data        = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        unique case (state_q)
            CSR_RD: begin
                r_csr_en = 1'b1;
                csr_addr = addr_q;
            end
            CSR_WR: begin
                w_csr_en = 1'b1;
                csr_addr = addr_q;
                unique case (op_q)
                    OP_CSRRS: w_csr_data = old_q | wdata_q;
                    OP_CSRRC: w_csr_data = old_q & ~wdata_q;
                    default:  w_csr_data = wdata_q;
                endcase
            end
            E_EPC: begin
                w_csr_en   = 1'b1;
                csr_addr   = A_MEPC;
                w_csr_data = pc_q;
            end
            E_CAUSE: begin
                w_csr_en   = 1'b1;
                csr_addr   = A_MCAUSE;
                w_csr_data = CAUSE_ECALL;
            end
            E_SRD, M_SRD: begin
                r_csr_en = 1'b1;
                csr_addr = A_MSTATUS;
            end
            E_SWR: begin
                w_csr_en          = 1'b1;
                csr_addr          = A_MSTATUS;
                w_csr_data        = old_q;
                w_csr_data[7]     = old_q[3];
                w_csr_data[3]     = 1'b0;
                w_csr_data[12:11] = MPP_M;
            end
            M_SWR: begin
                w_csr_en          = 1'b1;
                csr_addr          = A_MSTATUS;
                w_csr_data        = old_q;
                w_csr_data[3]     = old_q[7];
                w_csr_data[7]     = 1'b1;
                w_csr_data[12:11] = 2'b00;
            end
            E_VEC: begin
                r_csr_en = 1'b1;
                csr_addr = A_MTVEC;
            end
            M_EPC: begin
                r_csr_en = 1'b1;
                csr_addr = A_MEPC;
            end
            RESP: begin
                done = 1'b1;
                if (is_csr_op) rd_data = old_q;
                if (is_trap_op) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060240_trap_ctrl.sv
// Bench for ysyx_23060240_trap_ctrl: a behavioural CSR file answers reads,
// expected CSR writes and responses are queued per scenario and compared by
// a negedge monitor; latency / handshake checks are done inline per task.
module tb_ysyx_23060240_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_pc;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [11:0] csr_addr;
    logic [31:0] w_csr_data;
    logic        w_csr_en;
    logic        r_csr_en;
    logic [31:0] r_csr_data;
    logic        done;
    logic [31:0] rd_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_rd[$];
    logic        exp_rv[$];
    logic [31:0] exp_rpc[$];

    // CSR file model
    logic [31:0] csr_mem [4096];
    logic        poke_en;
    logic [11:0] poke_addr;
    logic [31:0] poke_val;

    ysyx_23060240_trap_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_pc(req_pc), .req_addr(req_addr), .req_wdata(req_wdata),
        .csr_addr(csr_addr), .w_csr_data(w_csr_data), .w_csr_en(w_csr_en),
        .r_csr_en(r_csr_en), .r_csr_data(r_csr_data), .done(done), .rd_data(rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign r_csr_data = csr_mem[csr_addr];

    always @(posedge clk) begin
        if (poke_en) csr_mem[poke_addr] <= poke_val;
        else if (w_csr_en) csr_mem[csr_addr] <= w_csr_data;
    end

    // Monitor: every CSR write and every done pulse is matched to the queues
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (w_csr_en === 1'b1 && r_csr_en === 1'b1) begin
                errors++; $display("FAIL strobe_excl: w_csr_en and r_csr_en both high");
            end
            checks++;
            if (w_csr_en !== 1'b1 && r_csr_en !== 1'b1 && csr_addr !== 12'h0) begin
                errors++; $display("FAIL addr_idle: csr_addr=%h want 000", csr_addr);
            end
            checks++;
            if (w_csr_en !== 1'b1 && w_csr_data !== 32'h0) begin
                errors++; $display("FAIL wdata_idle: w_csr_data=%h want 0", w_csr_data);
            end
            checks++;
            if ((done !== 1'b1 && rd_data !== 32'h0) || (redirect_valid !== 1'b1 && redirect_pc !== 32'h0)) begin
                errors++; $display("FAIL resp_idle: rd_data=%h redirect_pc=%h want 0", rd_data, redirect_pc);
            end
            if (w_csr_en === 1'b1) begin
                checks++;
                if (exp_wa.size() == 0) begin
                    errors++; $display("FAIL csr_write: unexpected write %h<=%h", csr_addr, w_csr_data);
                end else begin
                    logic [11:0] a; logic [31:0] d;
                    a = exp_wa.pop_front(); d = exp_wd.pop_front();
                    if (csr_addr !== a || w_csr_data !== d) begin
                        errors++; $display("FAIL csr_write: got %h<=%h want %h<=%h", csr_addr, w_csr_data, a, d);
                    end
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++; $display("FAIL done: unexpected done pulse");
                end else begin
                    logic [31:0] r; logic v; logic [31:0] p;
                    r = exp_rd.pop_front(); v = exp_rv.pop_front(); p = exp_rpc.pop_front();
                    if (rd_data !== r || redirect_valid !== v || redirect_pc !== p) begin
                        errors++;
                        $display("FAIL response: rd=%h rv=%b rpc=%h want rd=%h rv=%b rpc=%h",
                                 rd_data, redirect_valid, redirect_pc, r, v, p);
                    end
                end
            end else if (redirect_valid === 1'b1) begin
                checks++; errors++;
                $display("FAIL redirect: redirect_valid=1 without done");
            end
        end
    end

    task automatic poke(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_val = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
        exp_wa.push_back(a); exp_wd.push_back(d);
    endtask

    task automatic push_done(input logic [31:0] r, input logic v, input logic [31:0] p);
        exp_rd.push_back(r); exp_rv.push_back(v); exp_rpc.push_back(p);
    endtask

    // Issue one request and check handshake, busy and acceptance-to-done latency
    task automatic run_op(input logic [2:0] op, input logic [31:0] pc, input logic [11:0] addr,
                          input logic [31:0] wd, input int lat, input string nm);
        int n; bit seen; bit busy_ok;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_pc = pc; req_addr = addr; req_wdata = wd;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready: req_ready=%b want 1", nm, req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0; seen = 0; busy_ok = 1;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1 || req_ready !== 1'b0) busy_ok = 0;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != lat) begin
            errors++; $display("FAIL %s_latency: done at cycle %0d (seen=%0d) want %0d", nm, n, seen, lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++; $display("FAIL %s_busy: busy/req_ready wrong during sequence", nm);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || w_csr_en !== 1'b0 ||
            r_csr_en !== 1'b0 || csr_addr !== 12'h0 || redirect_valid !== 1'b0 || rd_data !== 32'h0) begin
            errors++; $display("FAIL reset_state: ready=%b busy=%b done=%b w=%b r=%b addr=%h want 1,0,0,0,0,000",
                               req_ready, busy, done, w_csr_en, r_csr_en, csr_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_csrrw();
        poke(12'h305, 32'h0);
        push_wr(12'h305, 32'h80000100);
        push_done(32'h0, 1'b0, 32'h0);
        run_op(3'd2, 32'h0, 12'h305, 32'h80000100, 3, "csrrw");
        poke(12'h340, 32'h1234_5678);
        push_wr(12'h340, 32'hdead_beef);
        push_done(32'h1234_5678, 1'b0, 32'h0);
        run_op(3'd2, 32'h0, 12'h340, 32'hdead_beef, 3, "csrrw_old");
    endtask

    task automatic test_csrrs_rc();
        poke(12'h342, 32'hb);
        push_done(32'hb, 1'b0, 32'h0);
        run_op(3'd3, 32'h0, 12'h342, 32'h0, 2, "csrrs_zero");
        poke(12'h300, 32'h8);
        push_wr(12'h300, 32'h88);
        push_done(32'h8, 1'b0, 32'h0);
        run_op(3'd3, 32'h0, 12'h300, 32'h80, 3, "csrrs");
        push_wr(12'h300, 32'h80);
        push_done(32'h88, 1'b0, 32'h0);
        run_op(3'd4, 32'h0, 12'h300, 32'h8, 3, "csrrc");
        push_done(32'h80, 1'b0, 32'h0);
        run_op(3'd4, 32'h0, 12'h300, 32'h0, 2, "csrrc_zero");
    endtask

    task automatic test_ecall();
        poke(12'h305, 32'h80000203);
        poke(12'h300, 32'h1808);
        push_wr(12'h341, 32'h80000010);
        push_wr(12'h342, 32'hb);
        push_wr(12'h300, 32'h1880);
        push_done(32'h0, 1'b1, 32'h80000200);
        run_op(3'd0, 32'h80000010, 12'h0, 32'h0, 6, "ecall");
    endtask

    task automatic test_mret();
        poke(12'h300, 32'h1880);
        poke(12'h341, 32'h80000014);
        push_wr(12'h300, 32'h0088);
        push_done(32'h0, 1'b1, 32'h80000014);
        run_op(3'd1, 32'h0, 12'h0, 32'h0, 4, "mret");
    endtask

    task automatic test_illegal();
        push_done(32'h0, 1'b0, 32'h0);
        run_op(3'd6, 32'h0, 12'h305, 32'hffff_ffff, 1, "illegal");
    endtask

    // ECALL with req_valid held; the op is switched to illegal while busy
    task automatic test_back_to_back();
        bit ok;
        poke(12'h305, 32'h80000400);
        poke(12'h300, 32'h0000_0000);
        push_wr(12'h341, 32'h80000040);
        push_wr(12'h342, 32'hb);
        push_wr(12'h300, 32'h1800);
        push_done(32'h0, 1'b1, 32'h80000400);
        push_done(32'h0, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_pc = 32'h80000040; req_addr = 12'h0; req_wdata = 32'h0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first_ready: req_ready=%b want 1", req_ready);
        end
        ok = 1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) req_op = 3'd5;
            if (busy !== (c <= 6) || req_ready !== (c == 7)) begin
                ok = 0;
                $display("b2b cycle %0d: busy=%b req_ready=%b", c, busy, req_ready);
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_hold: busy/req_ready wrong while held (see above)");
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_second: done=%b want 1 one cycle after accept", done);
        end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        poke(12'h305, 32'h80000100);
        poke(12'h300, 32'h8);
        push_wr(12'h341, 32'h80000080);
        push_wr(12'h342, 32'hb);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_pc = 32'h80000080;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);   // now in E_SRD
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_ready: req_ready=%b busy=%b want 1,0", req_ready, busy);
        end
        quiet = 1;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || w_csr_en !== 1'b0 || redirect_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL rstmid_quiet: activity after aborted sequence");
        end
        checks++;
        if (csr_mem[12'h300] !== 32'h8) begin
            errors++; $display("FAIL rstmid_mstatus: mstatus=%h want 00000008", csr_mem[12'h300]);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_pc = 32'h0;
        req_addr = 12'h0; req_wdata = 32'h0;
        poke_en = 1'b0; poke_addr = 12'h0; poke_val = 32'h0;
        test_reset();
        test_csrrw();
        test_csrrs_rc();
        test_ecall();
        test_mret();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_wa.size() != 0 || exp_rd.size() != 0) begin
            errors++; $display("FAIL leftover: %0d writes / %0d responses never seen", exp_wa.size(), exp_rd.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
